// File: rtl/updown_counter_dbcd.sv
`default_nettype none
// ============================================================================
// Module      : updown_counter_dbcd
// Description : Debounced push-button up/down counter with modulus, wrap or
//               saturate at the limits, synchronous load, and a sequential
//               double-dabble converter driving active-low 7-segment digits.
// Revision    : 1.0 - initial release
// ============================================================================
module updown_counter_dbcd #(
    parameter int WIDTH           = 7,
    parameter int MAX_VAL         = 99,
    parameter int DIGITS          = 2,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pb,
    input  logic                  select,
    input  logic                  wrap_en,
    input  logic                  load,
    input  logic [WIDTH-1:0]      load_val,
    output logic [WIDTH-1:0]      count,
    output logic                  at_max,
    output logic                  at_min,
    output logic                  bcd_valid,
    output logic [7*DIGITS-1:0]   seg
);

    localparam int DBW  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int BCW  = $clog2(WIDTH + 1);
    localparam int BCDW = 4 * DIGITS;
    localparam int DDW  = BCDW + WIDTH;

    localparam logic [WIDTH-1:0]    c_max_val    = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0]    c_one        = WIDTH'(1);
    localparam logic [DBW-1:0]      c_db_last    = DBW'(DEBOUNCE_CYCLES - 1);
    localparam logic [BCW-1:0]      c_last_shift = BCW'(WIDTH - 1);
    localparam logic [6:0]          c_glyph_zero = 7'b1000000;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_CONV = 1'b1
    } conv_state_t;

    // Active-low glyphs, bit order {g,f,e,d,c,b,a}
    function automatic logic [6:0] f_seg7(input logic [3:0] digit);
        logic [6:0] glyph;
        case (digit)
            4'd0:    glyph = 7'b1000000;
            4'd1:    glyph = 7'b1111001;
            4'd2:    glyph = 7'b0100100;
            4'd3:    glyph = 7'b0110000;
            4'd4:    glyph = 7'b0011001;
            4'd5:    glyph = 7'b0010010;
            4'd6:    glyph = 7'b0000010;
            4'd7:    glyph = 7'b1111000;
            4'd8:    glyph = 7'b0000000;
            4'd9:    glyph = 7'b0010000;
            default: glyph = 7'b1111111;
        endcase
        return glyph;
    endfunction

    logic                r_sync1;
    logic                r_sync2;
    logic                r_db_state;
    logic                r_db_prev;
    logic [DBW-1:0]      r_db_cnt;
    logic                w_press;
    logic [WIDTH-1:0]    r_count;
    logic [WIDTH-1:0]    w_count_next;
    logic                w_count_chg;
    conv_state_t         r_state;
    conv_state_t         w_state_next;
    logic                w_last_shift;
    logic [DDW-1:0]      r_dd;
    logic [DDW-1:0]      w_dd_adj;
    logic [DDW-1:0]      w_dd_shift;
    logic [BCW-1:0]      r_shift_cnt;
    logic                r_bcd_valid;
    logic [7*DIGITS-1:0] r_seg;
    logic [7*DIGITS-1:0] w_seg_new;

    // Two-flop synchroniser for the asynchronous button; idles released (1)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= pb;
            r_sync2 <= r_sync1;
        end
    end

    // Debouncer: accept a new level once it has disagreed for DEBOUNCE_CYCLES cycles
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_db_state <= 1'b1;
            r_db_prev  <= 1'b1;
            r_db_cnt   <= '0;
        end else begin
            r_db_prev <= r_db_state;
            if (r_sync2 == r_db_state) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == c_db_last) begin
                r_db_state <= r_sync2;
                r_db_cnt   <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + DBW'(1);
            end
        end
    end

    // Press event is the falling edge of the debounced level only
    assign w_press = r_db_prev & ~r_db_state;

    // Next count: load beats press; limits wrap or saturate
    always_comb begin
        w_count_next = r_count;
        if (load) begin
            w_count_next = (load_val > c_max_val) ? c_max_val : load_val;
        end else if (w_press) begin
            if (select) begin
                if (r_count == c_max_val) begin
                    w_count_next = wrap_en ? '0 : r_count;
                end else begin
                    w_count_next = r_count + c_one;
                end
            end else begin
                if (r_count == '0) begin
                    w_count_next = wrap_en ? c_max_val : r_count;
                end else begin
                    w_count_next = r_count - c_one;
                end
            end
        end
    end

    assign w_count_chg = (w_count_next != r_count);

    // Count register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else begin
            r_count <= w_count_next;
        end
    end

    // Converter state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Converter next state; a new count value always (re)starts a conversion
    always_comb begin
        w_state_next = r_state;
        w_last_shift = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_count_chg) begin
                    w_state_next = ST_CONV;
                end
            end
            ST_CONV: begin
                if (w_count_chg) begin
                    w_state_next = ST_CONV;
                end else if (r_shift_cnt == c_last_shift) begin
                    w_state_next = ST_IDLE;
                    w_last_shift = 1'b1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Add-3 to every BCD nibble >= 5 ahead of the shift
    always_comb begin
        w_dd_adj = r_dd;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_dd[WIDTH+4*i +: 4] >= 4'd5) begin
                w_dd_adj[WIDTH+4*i +: 4] = r_dd[WIDTH+4*i +: 4] + 4'd3;
            end
        end
    end

    assign w_dd_shift = w_dd_adj << 1;

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign w_seg_new[7*gi +: 7] = f_seg7(w_dd_shift[WIDTH+4*gi +: 4]);
        end
    endgenerate

    // Double-dabble datapath; seg keeps the last finished result until the next one lands
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dd        <= '0;
            r_shift_cnt <= '0;
            r_bcd_valid <= 1'b1;
            r_seg       <= {DIGITS{c_glyph_zero}};
        end else if (w_count_chg) begin
            r_dd        <= {{BCDW{1'b0}}, w_count_next};
            r_shift_cnt <= '0;
            r_bcd_valid <= 1'b0;
        end else if (r_state == ST_CONV) begin
            r_dd        <= w_dd_shift;
            r_shift_cnt <= r_shift_cnt + BCW'(1);
            if (w_last_shift) begin
                r_seg       <= w_seg_new;
                r_bcd_valid <= 1'b1;
            end
        end
    end

    assign count     = r_count;
    assign at_max    = (r_count == c_max_val);
    assign at_min    = (r_count == '0);
    assign bcd_valid = r_bcd_valid;
    assign seg       = r_seg;

endmodule
`default_nettype wire
